// File: rtl/branch_pkg.sv
// Shared encodings for the EX-stage branch resolution logic.
package branch_pkg;

   localparam logic [2:0] BR_BEQ  = 3'd0;
   localparam logic [2:0] BR_BNE  = 3'd1;
   localparam logic [2:0] BR_BLEZ = 3'd2;
   localparam logic [2:0] BR_BGTZ = 3'd3;
   localparam logic [2:0] BR_BLTZ = 3'd4;
   localparam logic [2:0] BR_BGEZ = 3'd5;
   localparam logic [2:0] BR_J    = 3'd6;
   localparam logic [2:0] BR_JR   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REDIRECT,
      ST_FLUSH
   } state_e;

   // Wide enough to hold FLUSH_CYCLES-1 for the largest legal FLUSH_CYCLES of 7.
   localparam int CNT_W = 3;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition and target evaluation.
module branch_cond
   import branch_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic [2:0]      br_op,
   input  logic [PC_W-1:0] op_a,
   input  logic [PC_W-1:0] op_b,
   input  logic [PC_W-1:0] pc_plus4,
   input  logic [PC_W-1:0] br_offset,
   input  logic [25:0]     j_index,
   output logic            taken,
   output logic [PC_W-1:0] target
);

   logic            a_neg;
   logic            a_zero;
   logic [PC_W-1:0] br_target;

   assign a_neg     = op_a[PC_W-1];
   assign a_zero    = (op_a == '0);
   assign br_target = pc_plus4 + (br_offset << 2);

   always_comb begin
      taken  = 1'b0;
      target = br_target;
      case (br_op)
         BR_BEQ:  taken = (op_a == op_b);
         BR_BNE:  taken = (op_a != op_b);
         BR_BLEZ: taken = a_neg | a_zero;
         BR_BGTZ: taken = ~a_neg & ~a_zero;
         BR_BLTZ: taken = a_neg;
         BR_BGEZ: taken = ~a_neg;
         BR_J: begin
            taken  = 1'b1;
            target = {pc_plus4[PC_W-1:28], j_index, 2'b00};
         end
         BR_JR: begin
            taken  = 1'b1;
            target = op_a;
         end
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage control-transfer resolution: PC redirect handshake and wrong-path flush.
// Optional statistics counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_W         = 32
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            br_valid,
   input  logic [2:0]      br_op,
   input  logic [PC_W-1:0] op_a,
   input  logic [PC_W-1:0] op_b,
   input  logic [PC_W-1:0] pc_plus4,
   input  logic [PC_W-1:0] br_offset,
   input  logic [25:0]     j_index,
   input  logic            ex_stall,
   input  logic            redirect_ready,
   output logic            redirect_valid,
   output logic [PC_W-1:0] redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
`ifdef BRANCH_STATS_EN
   output logic [31:0]     branch_count,
   output logic [31:0]     taken_count,
`endif
   output logic            busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PC_W-1:0]  redirect_pc_q;
   logic             taken;
   logic [PC_W-1:0]  target;
   logic             evaluate;

   branch_cond #(.PC_W(PC_W)) u_cond (
      .br_op     (br_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .pc_plus4  (pc_plus4),
      .br_offset (br_offset),
      .j_index   (j_index),
      .taken     (taken),
      .target    (target)
   );

   // Branches are only looked at in IDLE; anything seen while busy is wrong-path.
   assign evaluate = (state_q == ST_IDLE) && br_valid && !ex_stall;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         redirect_pc_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (evaluate && taken) begin
                  redirect_pc_q <= target;
                  state_q       <= ST_REDIRECT;
               end
            end
            ST_REDIRECT: begin
               if (redirect_ready) begin
                  if (FLUSH_CYCLES > 1) begin
                     state_q <= ST_FLUSH;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               if (!ex_stall) begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of registered state.
   assign redirect_valid = (state_q == ST_REDIRECT);
   assign redirect_pc    = redirect_pc_q;
   assign flush_if_id    = (state_q != ST_IDLE);
   assign flush_id_ex    = (state_q != ST_IDLE);
   assign busy           = (state_q != ST_IDLE);

`ifdef BRANCH_STATS_EN
   logic [31:0] branch_count_q;
   logic [31:0] taken_count_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         branch_count_q <= '0;
         taken_count_q  <= '0;
      end else if (evaluate) begin
         branch_count_q <= branch_count_q + 32'd1;
         if (taken) begin
            taken_count_q <= taken_count_q + 32'd1;
         end
      end
   end

   assign branch_count = branch_count_q;
   assign taken_count  = taken_count_q;
`endif

endmodule
